// File: rtl/matmul_index_sequencer_if.sv
// matmul_index_sequencer_if: job request and MAC-datapath control bundle for one core's index sequencer.
// master (the sequencer) takes start, the dimensions, core_id, num_cores and stall, and drives the
// indices, the A/B/C addresses, the mac_clear/mac_en/c_we strobes and busy/done. slave is the mirror view.
interface matmul_index_sequencer_if #(parameter int DW = 8, parameter int AW = 16);
  logic start;
  logic [DW-1:0] dim_m, dim_n, dim_p, core_id, num_cores;
  logic stall;
  logic [DW-1:0] idx_i, idx_j, idx_k;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic mac_clear, mac_en, c_we, busy, done;
  modport master(
    input start, dim_m, dim_n, dim_p, core_id, num_cores, stall,
    output idx_i, idx_j, idx_k, a_addr, b_addr, c_addr, mac_clear, mac_en, c_we, busy, done
  );
  modport slave(
    output start, dim_m, dim_n, dim_p, core_id, num_cores, stall,
    input idx_i, idx_j, idx_k, a_addr, b_addr, c_addr, mac_clear, mac_en, c_we, busy, done
  );
endinterface

// File: rtl/matmul_index_sequencer.sv
// matmul_index_sequencer: (i, j, k) loop controller and address generator for one core of the matrix multiplier.
// Ports: clk, reset (sync, active-high), bus (matmul_index_sequencer_if.master: job inputs, indices,
// A/B/C addresses, MAC strobes, busy/done). Rows core_id, core_id+stride, ... are handled by this core.
// Optional feature: define SEQ_STALL_EN to let stall freeze the sequence in CLEAR/MAC/WRITE;
// without it the stall input has no effect.
module matmul_index_sequencer #(parameter int DW = 8, parameter int AW = 16) (
  input logic clk,
  input logic reset,
  matmul_index_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, WRITE, DONE} state_t;
  state_t st, st_n;
  logic [DW-1:0] m, n, p, i, j, k, m_n, n_n, p_n, i_n, j_n, k_n, eff;
  logic [AW-1:0] row_a, row_c, step_a, step_c, a, b, c;
  logic [AW-1:0] row_a_n, row_c_n, step_a_n, step_c_n, a_n, b_n, c_n;
  logic clr_q, en_q, we_q, busy_q, done_q, hold, empty;
  // Shift-add scaling, used only once per job to seed the row bases and row strides;
  // every per-element step afterwards is a single add.
  function automatic logic [AW-1:0] scale(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [AW-1:0] acc;
    acc = '0;
    for (int s = 0; s < DW; s++) acc = y[s] ? acc + (AW'(x) << s) : acc;
    return acc;
  endfunction
  assign eff = bus.num_cores == '0 ? DW'(1) : bus.num_cores;
  assign empty = bus.dim_m == '0 || bus.dim_n == '0 || bus.dim_p == '0 || bus.core_id >= bus.dim_m;
`ifdef SEQ_STALL_EN
  assign hold = bus.stall && (st == CLEAR || st == MAC || st == WRITE);
`else
  assign hold = 1'b0 & bus.stall;
`endif
  always_comb begin
    st_n = st;
    m_n = m;
    n_n = n;
    p_n = p;
    i_n = i;
    j_n = j;
    k_n = k;
    row_a_n = row_a;
    row_c_n = row_c;
    step_a_n = step_a;
    step_c_n = step_c;
    a_n = a;
    b_n = b;
    c_n = c;
    case (st)
      IDLE: if (bus.start) begin
        m_n = bus.dim_m;
        n_n = bus.dim_n;
        p_n = bus.dim_p;
        i_n = bus.core_id;
        j_n = '0;
        k_n = '0;
        row_a_n = scale(bus.core_id, bus.dim_p);
        row_c_n = scale(bus.core_id, bus.dim_n);
        step_a_n = scale(eff, bus.dim_p);
        step_c_n = scale(eff, bus.dim_n);
        a_n = row_a_n;
        b_n = '0;
        c_n = row_c_n;
        st_n = empty ? DONE : CLEAR;
      end
      CLEAR: begin
        k_n = '0;
        st_n = MAC;
      end
      MAC: if (k == p - 1'b1) st_n = WRITE;
      else begin
        k_n = k + 1'b1;
        a_n = a + 1'b1;
        b_n = b + AW'(n);
      end
      WRITE: begin
        k_n = '0;
        st_n = CLEAR;
        if (j < n - 1'b1) begin
          j_n = j + 1'b1;
          a_n = row_a;
          b_n = AW'(j_n);
          c_n = c + 1'b1;
        end else if ({1'b0, i} + {1'b0, eff_q()} < {1'b0, m}) begin
          i_n = i + eff_q();
          j_n = '0;
          row_a_n = row_a + step_a;
          row_c_n = row_c + step_c;
          a_n = row_a_n;
          b_n = '0;
          c_n = row_c_n;
        end else st_n = DONE;
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
  logic [DW-1:0] stride;
  function automatic logic [DW-1:0] eff_q();
    return stride;
  endfunction
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      {m, n, p, stride, i, j, k} <= '0;
      {row_a, row_c, step_a, step_c, a, b, c} <= '0;
      {clr_q, en_q, we_q, busy_q, done_q} <= '0;
    end else if (!hold) begin
      st <= st_n;
      m <= m_n;
      n <= n_n;
      p <= p_n;
      stride <= (st == IDLE && bus.start) ? eff : stride;
      i <= i_n;
      j <= j_n;
      k <= k_n;
      row_a <= row_a_n;
      row_c <= row_c_n;
      step_a <= step_a_n;
      step_c <= step_c_n;
      a <= a_n;
      b <= b_n;
      c <= c_n;
      clr_q <= st_n == CLEAR;
      en_q <= st_n == MAC;
      we_q <= st_n == WRITE;
      busy_q <= st_n == CLEAR || st_n == MAC || st_n == WRITE;
      done_q <= st_n == DONE;
    end
  assign bus.idx_i = i;
  assign bus.idx_j = j;
  assign bus.idx_k = k;
  assign bus.a_addr = a;
  assign bus.b_addr = b;
  assign bus.c_addr = c;
  // A frozen cycle repeats the current step later, so its strobe must not fire now.
  assign bus.mac_clear = clr_q & ~hold;
  assign bus.mac_en = en_q & ~hold;
  assign bus.c_we = we_q & ~hold;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
